i2s_rx_frontend: RTL and testbench
==================================

// Module: i2s_rx_frontend
// PURPOSE
//  - Oversampling I2S receiver in the m_clk (49.152 MHz) domain, upstream of the DSP/DAC datapath.
//  - Synchronises i2s_sck/i2s_lrclk/i2s_sdin, deserialises 24-bit stereo frames and presents
//    a left/right pair with a 1-cycle valid strobe.
//  - Reports lock and framing errors for the I2C status map.
// PARAMETERS
//  DATA_W      24   sample width captured per slot (MSB first)
//  SLOT_W      32   sck cycles per lrclk half-frame (64fs framing)
//  SYNC_STAGES 2    flops in each pin synchroniser (>=2)
//  TIMEOUT     64   m_clk cycles without an sck rising edge before lock is dropped
//  LOCK_FRAMES 2    consecutive good frames required to assert locked
// PORTS
//  m_clk        in   1       master clock, 49.152 MHz
//  rst_n        in   1       asynchronous active-low reset
//  i2s_sck      in   1       I2S bit clock, async to m_clk, <= m_clk/8
//  i2s_lrclk    in   1       word select: 0 = left, 1 = right
//  i2s_sdin     in   1       serial data
//  left_data    out  DATA_W  last complete left sample, two's complement
//  right_data   out  DATA_W  last complete right sample, two's complement
//  sample_valid out  1       1-cycle pulse, new L/R pair on left_data/right_data
//  locked       out  1       framing stable for LOCK_FRAMES frames
//  frame_err    out  1       1-cycle pulse on bad slot length or timeout
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in HUNT; counters 0; sync flops 0.
//  - Pins pass SYNC_STAGES flops; one extra flop gives sck rise (sck_r) / lrclk toggle (lr_t)
//    detection. Everything below advances only on sck_r.
//  - FSM: HUNT -> (lr_t seen) ALIGN -> (next sck_r) RECV; RECV -> HUNT on error/timeout.
//  - I2S format: MSB is sampled on the 2nd sck_r after the lrclk transition (one-bit delay).
//  - bit_cnt counts sck_r within a slot and clears on lr_t. Bits 0..DATA_W-1 shift into
//    shreg MSB first; bits >= DATA_W are ignored.
//  - Slot end (lr_t in RECV): if bit_cnt != SLOT_W -> frame_err pulse, good-frame count cleared,
//    slot discarded; else the slot is stored in hold_l or hold_r, chosen by the lrclk level before the toggle.
//  - Right slot completes (lrclk 1->0) with a valid left held -> left_data/right_data update and
//    sample_valid pulses in the same cycle. Latency: 1 m_clk after the synchronised lr_t edge.
//  - Outputs hold their value between pulses. A right slot without a preceding good left slot
//    updates nothing.
//  - good_cnt saturates at LOCK_FRAMES; locked = (good_cnt == LOCK_FRAMES).
//  - Timeout: to_cnt clears on sck_r and saturates at TIMEOUT. On reaching TIMEOUT: frame_err
//    pulses once, locked drops, FSM -> HUNT, left_data/right_data forced to 0 (mute).
//  - An sck_r and lr_t in the same cycle: the bit is counted into the closing slot first.
//  - Reset mid-frame: all state lost; first pair is output only after a full left+right.
// CONFIGURATION
//  I2S_RX_LJ_EN defined: adds input port fmt_lj (1 bit, static). fmt_lj = 1 selects
//    left-justified format (MSB on the 1st sck_r after lr_t, no delay); fmt_lj = 0 selects I2S.
//  I2S_RX_LJ_EN undefined: no fmt_lj port; I2S format only.
// STRUCTURE
//  - Shared package i2s_pkg: FSM state typedef {HUNT, ALIGN, RECV}; constants DATA_W_DEF=24,
//    SLOT_W_DEF=32.
//  - Sub-module i2s_pin_sync: SYNC_STAGES synchroniser plus edge detector, instanced once per pin.
//  - Top holds the FSM, counters, shift and hold registers.
// TESTING
//  - 64fs I2S at 48 kHz, L=24'h7FFFFF, R=24'h800001 -> pulse every 1024 m_clk with those values;
//    locked high after the 2nd pair.
//  - Stop sck mid-frame -> frame_err pulses 64 m_clk after the last edge; locked=0; data=0.
//  - One slot of 31 sck (short lrclk) -> single frame_err, that pair dropped, locked drops,
//    relocks after 2 good frames.
//  - Assert rst_n low mid right slot -> outputs 0 at once; first pulse only after a complete L+R.
//  - Bit walk: L=24'h000001, R=24'h400000 -> exact values out, confirming MSB-first and one-bit delay.
//  - I2S_RX_LJ_EN with fmt_lj=1 and LJ stimulus L=24'h123456 -> left_data=24'h123456.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S receive front end.
//   state_t    : receiver FSM states (HUNT, ALIGN, RECV)
//   DATA_W_DEF : default captured sample width
//   SLOT_W_DEF : default sck cycles per lrclk half-frame
package i2s_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ALIGN = 2'd1,
    RECV  = 2'd2
  } state_t;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned SLOT_W_DEF = 32;

endpackage

// File: rtl/i2s_pin_sync.sv
// Pin synchroniser with edge detection for one asynchronous I2S pin.
//   clk      in  : sampling clock
//   rst_n    in  : asynchronous active-low reset
//   din      in  : asynchronous pin
//   level    out : synchronised pin level (registered)
//   rise_c   out : combinational 0->1 strobe on the synchronised level
//   toggle_c out : combinational any-change strobe on the synchronised level
module i2s_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic toggle_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic                   armed;

  // Synchroniser chain, one delay flop for edge detection, and a fill tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are suppressed until the chain holds real pin samples, so a pin
  // sitting high at reset release does not look like a transition.
  assign armed    = fill_q[SYNC_STAGES];
  assign level    = sync_q[SYNC_STAGES-1];
  assign rise_c   = armed & level & ~prev_q;
  assign toggle_c = armed & (level ^ prev_q);

endmodule

// File: rtl/i2s_rx_frontend.sv
// Oversampling I2S receiver: synchronises sck/lrclk/sdin into m_clk, deserialises
// stereo slots MSB first and presents an L/R pair with a one-cycle valid strobe.
// Optional macro I2S_RX_LJ_EN adds the fmt_lj port (1 = left-justified, 0 = I2S).
//   m_clk        in  : master clock
//   rst_n        in  : asynchronous active-low reset
//   i2s_sck      in  : bit clock (async)
//   i2s_lrclk    in  : word select, 0 = left, 1 = right (async)
//   i2s_sdin     in  : serial data (async)
//   fmt_lj       in  : format select (only with I2S_RX_LJ_EN)
//   left_data    out : last complete left sample
//   right_data   out : last complete right sample
//   sample_valid out : one-cycle pulse when a new pair is presented
//   locked       out : LOCK_FRAMES consecutive good frames seen
//   frame_err    out : one-cycle pulse on bad slot length or sck timeout
module i2s_rx_frontend
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SLOT_W      = SLOT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic              m_clk,
  input  logic              rst_n,
  input  logic              i2s_sck,
  input  logic              i2s_lrclk,
  input  logic              i2s_sdin,
`ifdef I2S_RX_LJ_EN
  input  logic              fmt_lj,
`endif
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              locked,
  output logic              frame_err
);

  localparam int unsigned CNT_W  = $clog2(SLOT_W + 2);
  localparam int unsigned CNT_W1 = CNT_W + 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);

  logic lj;
`ifdef I2S_RX_LJ_EN
  assign lj = fmt_lj;
`else
  assign lj = 1'b0;
`endif

  logic sck_r, lr_t, lr_lvl, sd;
  logic unused_sck_lvl, unused_sck_tog, unused_lr_rise, unused_sd_rise, unused_sd_tog;

  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(m_clk), .rst_n(rst_n), .din(i2s_sck),
    .level(unused_sck_lvl), .rise_c(sck_r), .toggle_c(unused_sck_tog)
  );

  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lr (
    .clk(m_clk), .rst_n(rst_n), .din(i2s_lrclk),
    .level(lr_lvl), .rise_c(unused_lr_rise), .toggle_c(lr_t)
  );

  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
    .clk(m_clk), .rst_n(rst_n), .din(i2s_sdin),
    .level(sd), .rise_c(unused_sd_rise), .toggle_c(unused_sd_tog)
  );

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [DATA_W-1:0] hold_l, hold_l_nxt;
  logic              hold_l_vld, hold_l_vld_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [DATA_W-1:0] left_nxt, right_nxt;
  logic              valid_nxt, err_nxt, locked_nxt;

  logic              shift_en, slot_end, slot_good, to_hit;
  logic [CNT_W1-1:0] cnt_eff;
  logic [DATA_W-1:0] shifted, slot_word;

  // Slot bit position: LJ takes the MSB on the first sck_r, I2S one later.
  assign shift_en = sck_r && (state != HUNT) &&
                    (lj ? (bit_cnt < CNT_W'(DATA_W))
                        : ((bit_cnt != '0) && (bit_cnt <= CNT_W'(DATA_W))));
  assign shifted  = {shreg[DATA_W-2:0], sd};

  // A bit arriving with the closing lr_t still belongs to the closing slot.
  assign slot_word = shift_en ? shifted : shreg;
  assign cnt_eff   = {1'b0, bit_cnt} + CNT_W1'(sck_r);
  assign slot_end  = lr_t && (state == RECV);
  assign slot_good = (cnt_eff == CNT_W1'(SLOT_W));

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    hold_l_nxt     = hold_l;
    hold_l_vld_nxt = hold_l_vld;
    to_cnt_nxt     = to_cnt;
    good_nxt       = good_cnt;
    left_nxt       = left_data;
    right_nxt      = right_data;
    valid_nxt      = 1'b0;
    err_nxt        = 1'b0;

    if (lr_t) begin
      bit_cnt_nxt = '0;
      shreg_nxt   = '0;
    end else begin
      if (sck_r && (bit_cnt != CNT_W'(SLOT_W + 1))) bit_cnt_nxt = bit_cnt + CNT_W'(1);
      if (shift_en) shreg_nxt = shifted;
    end

    // Watchdog only runs once a frame is being tracked.
    if ((state == HUNT) || sck_r) to_cnt_nxt = '0;
    else if (to_cnt != TO_W'(TIMEOUT)) to_cnt_nxt = to_cnt + TO_W'(1);
    to_hit = (to_cnt_nxt == TO_W'(TIMEOUT)) && (to_cnt != TO_W'(TIMEOUT));

    case (state)
      HUNT: begin
        hold_l_vld_nxt = 1'b0;
        if (lr_t) state_nxt = ALIGN;
      end
      ALIGN: begin
        if (sck_r && !lr_t) state_nxt = RECV;
      end
      RECV: begin
        if (slot_end) begin
          if (!slot_good) begin
            err_nxt        = 1'b1;
            good_nxt       = '0;
            hold_l_vld_nxt = 1'b0;
            state_nxt      = HUNT;
          end else if (lr_lvl) begin
            // lrclk now high: the slot that just closed was the left one.
            hold_l_nxt     = slot_word;
            hold_l_vld_nxt = 1'b1;
          end else if (hold_l_vld) begin
            left_nxt       = hold_l;
            right_nxt      = slot_word;
            valid_nxt      = 1'b1;
            hold_l_vld_nxt = 1'b0;
            if (good_cnt != GOOD_W'(LOCK_FRAMES)) good_nxt = good_cnt + GOOD_W'(1);
          end
        end
      end
      default: state_nxt = HUNT;
    endcase

    // Lost bit clock: report once, drop lock and mute.
    if (to_hit) begin
      state_nxt      = HUNT;
      err_nxt        = 1'b1;
      good_nxt       = '0;
      hold_l_vld_nxt = 1'b0;
      left_nxt       = '0;
      right_nxt      = '0;
      valid_nxt      = 1'b0;
    end

    locked_nxt = (good_nxt == GOOD_W'(LOCK_FRAMES));
  end

  // State and output registers.
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      bit_cnt      <= '0;
      shreg        <= '0;
      hold_l       <= '0;
      hold_l_vld   <= 1'b0;
      to_cnt       <= '0;
      good_cnt     <= '0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shreg        <= shreg_nxt;
      hold_l       <= hold_l_nxt;
      hold_l_vld   <= hold_l_vld_nxt;
      to_cnt       <= to_cnt_nxt;
      good_cnt     <= good_nxt;
      left_data    <= left_nxt;
      right_data   <= right_nxt;
      sample_valid <= valid_nxt;
      locked       <= locked_nxt;
      frame_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Directed bench for i2s_rx_frontend: 64fs framing, sck = m_clk/16.
module tb_i2s_rx_frontend;

  logic        m_clk, rst_n, sck, lrclk, sdin;
  logic [23:0] left_data, right_data;
  logic        sample_valid, locked, frame_err;
`ifdef I2S_RX_LJ_EN
  logic        fmt_lj;
`endif

  i2s_rx_frontend dut (
    .m_clk(m_clk), .rst_n(rst_n),
    .i2s_sck(sck), .i2s_lrclk(lrclk), .i2s_sdin(sdin),
`ifdef I2S_RX_LJ_EN
    .fmt_lj(fmt_lj),
`endif
    .left_data(left_data), .right_data(right_data),
    .sample_valid(sample_valid), .locked(locked), .frame_err(frame_err)
  );

  initial begin
    m_clk = 1'b0;
    forever #5 m_clk = ~m_clk;
  end

  // Pulse capture; comparisons happen in the test tasks.
  logic [23:0] q_l[$];
  logic [23:0] q_r[$];
  logic        q_lk[$];
  time         q_t[$];
  int          err_cnt = 0;
  time         err_t = 0;
  time         last_tog_t, last_rise_t;
  int          checks, errors;

  always @(negedge m_clk) begin
    if (sample_valid === 1'b1) begin
      q_l.push_back(left_data);
      q_r.push_back(right_data);
      q_lk.push_back(locked);
      q_t.push_back($time);
    end
    if (frame_err === 1'b1) begin
      err_cnt++;
      err_t = $time;
    end
  end

  // One sck period per slot bit; data and lrclk change on the falling edge.
  task automatic drive_slot(input logic ws, input logic [23:0] w, input int n, input logic lj);
    for (int k = 0; k < n; k++) begin
      int   idx;
      logic b;
      idx = lj ? k : k - 1;
      b = (idx >= 0 && idx < 24) ? w[23 - idx] : 1'b0;
      sck = 1'b0;
      if (lrclk !== ws) last_tog_t = $time;
      lrclk = ws;
      sdin  = b;
      #80;
      sck = 1'b1;
      last_rise_t = $time;
      #80;
    end
  endtask

  task automatic drive_frame(input logic [23:0] l, input logic [23:0] r,
                             input int nl, input int nr, input logic lj);
    drive_slot(1'b0, l, nl, lj);
    drive_slot(1'b1, r, nr, lj);
  endtask

  // Closing lrclk edge after the last right slot, then a short idle.
  task automatic drive_toggle();
    sck = 1'b0;
    last_tog_t = $time;
    lrclk = 1'b0;
    sdin = 1'b0;
    #200;
  endtask

  task automatic apply_reset();
    @(negedge m_clk);
    rst_n = 1'b0;
    sck   = 1'b0;
    lrclk = 1'b1;
    sdin  = 1'b0;
    #50;
    rst_n = 1'b1;
    #100;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sck   = 1'b0;
    lrclk = 1'b1;
    sdin  = 1'b0;
    #30;
    checks++; if (left_data !== 24'h0) begin errors++; $display("FAIL reset_left: got %h want 000000", left_data); end
    checks++; if (right_data !== 24'h0) begin errors++; $display("FAIL reset_right: got %h want 000000", right_data); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
  endtask

  task automatic test_stream_48k();
    int b, eb, n;
    apply_reset();
    b = q_l.size(); eb = err_cnt;
    repeat (4) drive_frame(24'h7FFFFF, 24'h800001, 32, 32, 1'b0);
    drive_toggle();
    n = q_l.size() - b;
    checks++; if (n !== 4) begin errors++; $display("FAIL stream_count: got %0d want 4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      checks++; if (q_l[b+i] !== 24'h7FFFFF) begin errors++; $display("FAIL stream_left[%0d]: got %h want 7fffff", i, q_l[b+i]); end
      checks++; if (q_r[b+i] !== 24'h800001) begin errors++; $display("FAIL stream_right[%0d]: got %h want 800001", i, q_r[b+i]); end
    end
    for (int i = 1; i < n && i < 4; i++) begin
      checks++; if (q_t[b+i] - q_t[b+i-1] !== 10240) begin errors++; $display("FAIL stream_spacing[%0d]: got %0t want 10240", i, q_t[b+i] - q_t[b+i-1]); end
    end
    if (n >= 2) begin
      checks++; if (q_lk[b] !== 1'b0) begin errors++; $display("FAIL stream_lock_pair1: got %b want 0", q_lk[b]); end
      checks++; if (q_lk[b+1] !== 1'b1) begin errors++; $display("FAIL stream_lock_pair2: got %b want 1", q_lk[b+1]); end
    end
    if (n >= 1) begin
      checks++; if (q_t[b+n-1] - last_tog_t !== 30) begin errors++; $display("FAIL stream_latency: got %0t want 30", q_t[b+n-1] - last_tog_t); end
    end
    checks++; if (err_cnt - eb !== 0) begin errors++; $display("FAIL stream_errs: got %0d want 0", err_cnt - eb); end
  endtask

  task automatic test_bit_walk();
    int b, n;
    apply_reset();
    b = q_l.size();
    repeat (2) drive_frame(24'h000001, 24'h400000, 32, 32, 1'b0);
    drive_toggle();
    n = q_l.size() - b;
    checks++; if (n !== 2) begin errors++; $display("FAIL walk_count: got %0d want 2", n); end
    for (int i = 0; i < n && i < 2; i++) begin
      checks++; if (q_l[b+i] !== 24'h000001) begin errors++; $display("FAIL walk_left[%0d]: got %h want 000001", i, q_l[b+i]); end
      checks++; if (q_r[b+i] !== 24'h400000) begin errors++; $display("FAIL walk_right[%0d]: got %h want 400000", i, q_r[b+i]); end
    end
  endtask

  task automatic test_timeout();
    int b, eb, n;
    apply_reset();
    b = q_l.size(); eb = err_cnt;
    repeat (3) drive_frame(24'h5A5A5A, 24'hA5A5A5, 32, 32, 1'b0);
    drive_slot(1'b0, 24'h5A5A5A, 10, 1'b0);
    n = q_l.size() - b;
    checks++; if (n !== 3) begin errors++; $display("FAIL to_pairs: got %0d want 3", n); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL to_locked_before: got %b want 1", locked); end
    checks++; if (left_data !== 24'h5A5A5A) begin errors++; $display("FAIL to_left_before: got %h want 5a5a5a", left_data); end
    #1500;
    checks++; if (err_cnt - eb !== 1) begin errors++; $display("FAIL to_err_count: got %0d want 1", err_cnt - eb); end
    checks++; if (err_t - last_rise_t !== 670) begin errors++; $display("FAIL to_err_delay: got %0t want 670", err_t - last_rise_t); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL to_locked_after: got %b want 0", locked); end
    checks++; if (left_data !== 24'h0) begin errors++; $display("FAIL to_left_mute: got %h want 000000", left_data); end
    checks++; if (right_data !== 24'h0) begin errors++; $display("FAIL to_right_mute: got %h want 000000", right_data); end
    checks++; if (q_l.size() - b !== 3) begin errors++; $display("FAIL to_no_extra_pair: got %0d want 3", q_l.size() - b); end
  endtask

  task automatic test_short_slot();
    int   b, eb, n;
    int   exp_fr [6] = '{1, 2, 3, 5, 6, 7};
    logic exp_lk [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    apply_reset();
    b = q_l.size(); eb = err_cnt;
    for (int i = 1; i <= 7; i++)
      drive_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i), (i == 4) ? 31 : 32, 32, 1'b0);
    drive_toggle();
    n = q_l.size() - b;
    checks++; if (n !== 6) begin errors++; $display("FAIL short_pairs: got %0d want 6", n); end
    checks++; if (err_cnt - eb !== 1) begin errors++; $display("FAIL short_errs: got %0d want 1", err_cnt - eb); end
    for (int i = 0; i < n && i < 6; i++) begin
      checks++; if (q_l[b+i] !== 24'h100000 + 24'(exp_fr[i])) begin errors++; $display("FAIL short_left[%0d]: got %h want %h", i, q_l[b+i], 24'h100000 + 24'(exp_fr[i])); end
      checks++; if (q_r[b+i] !== 24'h200000 + 24'(exp_fr[i])) begin errors++; $display("FAIL short_right[%0d]: got %h want %h", i, q_r[b+i], 24'h200000 + 24'(exp_fr[i])); end
      checks++; if (q_lk[b+i] !== exp_lk[i]) begin errors++; $display("FAIL short_lock[%0d]: got %b want %b", i, q_lk[b+i], exp_lk[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int b, eb, n;
    apply_reset();
    drive_frame(24'h0ABCDE, 24'h0FEDCB, 32, 32, 1'b0);
    drive_slot(1'b0, 24'h111111, 32, 1'b0);
    drive_slot(1'b1, 24'h222222, 10, 1'b0);
    checks++; if (left_data !== 24'h0ABCDE) begin errors++; $display("FAIL rmid_left_before: got %h want 0abcde", left_data); end
    checks++; if (right_data !== 24'h0FEDCB) begin errors++; $display("FAIL rmid_right_before: got %h want 0fedcb", right_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (left_data !== 24'h0) begin errors++; $display("FAIL rmid_left_reset: got %h want 000000", left_data); end
    checks++; if (right_data !== 24'h0) begin errors++; $display("FAIL rmid_right_reset: got %h want 000000", right_data); end
    #49;
    rst_n = 1'b1;
    b = q_l.size(); eb = err_cnt;
    drive_slot(1'b1, 24'h222222, 22, 1'b0);
    drive_frame(24'h333333, 24'h444444, 32, 32, 1'b0);
    drive_frame(24'h555555, 24'h666666, 32, 32, 1'b0);
    drive_toggle();
    n = q_l.size() - b;
    checks++; if (n !== 2) begin errors++; $display("FAIL rmid_pairs: got %0d want 2", n); end
    if (n >= 2) begin
      checks++; if (q_l[b] !== 24'h333333) begin errors++; $display("FAIL rmid_left1: got %h want 333333", q_l[b]); end
      checks++; if (q_r[b] !== 24'h444444) begin errors++; $display("FAIL rmid_right1: got %h want 444444", q_r[b]); end
      checks++; if (q_l[b+1] !== 24'h555555) begin errors++; $display("FAIL rmid_left2: got %h want 555555", q_l[b+1]); end
      checks++; if (q_r[b+1] !== 24'h666666) begin errors++; $display("FAIL rmid_right2: got %h want 666666", q_r[b+1]); end
    end
    checks++; if (err_cnt - eb !== 0) begin errors++; $display("FAIL rmid_errs: got %0d want 0", err_cnt - eb); end
  endtask

`ifdef I2S_RX_LJ_EN
  task automatic test_lj();
    int b, n;
    fmt_lj = 1'b1;
    apply_reset();
    b = q_l.size();
    repeat (2) drive_frame(24'h123456, 24'hABCDEF, 32, 32, 1'b1);
    drive_toggle();
    n = q_l.size() - b;
    checks++; if (n !== 2) begin errors++; $display("FAIL lj_pairs: got %0d want 2", n); end
    for (int i = 0; i < n && i < 2; i++) begin
      checks++; if (q_l[b+i] !== 24'h123456) begin errors++; $display("FAIL lj_left[%0d]: got %h want 123456", i, q_l[b+i]); end
      checks++; if (q_r[b+i] !== 24'hABCDEF) begin errors++; $display("FAIL lj_right[%0d]: got %h want abcdef", i, q_r[b+i]); end
    end
    fmt_lj = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    last_tog_t = 0;
    last_rise_t = 0;
`ifdef I2S_RX_LJ_EN
    fmt_lj = 1'b0;
`endif
    test_reset();
    test_stream_48k();
    test_bit_walk();
    test_timeout();
    test_short_slot();
    test_reset_mid_frame();
`ifdef I2S_RX_LJ_EN
    test_lj();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
